// File: rtl/lcd_bus_decoder.sv
// Receive-side model of an HD44780-style 8-bit LCD bus: decodes E falling-edge strobes and keeps a 2x16 shadow.
// Optional busy-flag emulation (IDLE/BUSY FSM, dropped-strobe counter) is compiled in with `define LCD_BUSY_EN.
module lcd_bus_decoder #(
    parameter int BUSY_LONG  = 16,
    parameter int BUSY_SHORT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cur_addr,
    output logic       disp_on,
    output logic       entry_inc,
    output logic       cmd_stb,
    output logic       data_stb,
    output logic       rw_err,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam logic [7:0] SPACE = 8'h20;

    // DDRAM address step with the HD44780 two-line wrap; invalid addresses step as plain 7-bit +/-1.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    logic       e_q, rs_q, rw_q;
    logic [7:0] d_q;
    logic       strobe, rw_strobe, wr_strobe, accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q  <= 1'b0;
            rs_q <= 1'b0;
            rw_q <= 1'b0;
            d_q  <= 8'h00;
        end else begin
            e_q  <= LCD_E;
            rs_q <= LCD_RS;
            rw_q <= LCD_RW;
            d_q  <= LCD_DATA;
        end
    end

    // The strobe uses rs_q/rw_q/d_q, i.e. the bus as it was while E was still high.
    assign strobe    = e_q & ~LCD_E;
    assign rw_strobe = strobe & rw_q;
    assign wr_strobe = strobe & ~rw_q;

`ifdef LCD_BUSY_EN
    typedef enum logic {IDLE, BUSY} state_e;
    localparam int CNT_W = 16;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, load_len;
    logic [7:0]       drop_q, drop_d;
    logic             is_long;

    // Clear (00000001) and home (0000001x) are the slow instructions.
    assign is_long  = ~rs_q & (d_q[7:2] == 6'd0) & (d_q[1:0] != 2'd0);
    assign load_len = is_long ? CNT_W'(BUSY_LONG) : CNT_W'(BUSY_SHORT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_strobe) begin
                    accept = 1'b1;
                    if (load_len != '0) begin
                        state_d = BUSY;
                        cnt_d   = load_len;
                    end
                end
            end
            BUSY: begin
                if (wr_strobe && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
                if (cnt_q <= CNT_W'(1)) state_d = IDLE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign busy     = (state_q == BUSY);
    assign drop_cnt = drop_q;
`else
    logic [31:0] busy_cfg_unused;

    assign busy_cfg_unused = BUSY_LONG + BUSY_SHORT;
    assign accept          = wr_strobe;
    assign busy            = 1'b0;
    assign drop_cnt        = 8'h00;
`endif

    logic [7:0] shadow_q [32];
    logic [7:0] shadow_d [32];
    logic [6:0] addr_q, addr_d;
    logic       disp_q, disp_d;
    logic       inc_q, inc_d;
    logic       cmd_stb_q, cmd_stb_d;
    logic       data_stb_q, data_stb_d;
    logic       rw_err_q, rw_err_d;
    logic [7:0] rd_char_q;

    // NOTE: combinational next-state uses blocking '=' with every target defaulted first (no latches);
    // the registers below take those values with non-blocking '<='.
    always_comb begin
        shadow_d   = shadow_q;
        addr_d     = addr_q;
        disp_d     = disp_q;
        inc_d      = inc_q;
        cmd_stb_d  = 1'b0;
        data_stb_d = 1'b0;
        rw_err_d   = rw_strobe;
        if (accept) begin
            if (rs_q) begin
                // Only columns 0-15 of each line are visible; the rest of DDRAM is accepted but not mirrored.
                if (addr_q[5:4] == 2'b00) shadow_d[{addr_q[6], addr_q[3:0]}] = d_q;
                addr_d     = step_addr(addr_q, inc_q);
                data_stb_d = 1'b1;
            end else begin
                cmd_stb_d = 1'b1;
                casez (d_q)
                    8'b1???????: addr_d = d_q[6:0];
                    8'b0001????: if (!d_q[3]) addr_d = step_addr(addr_q, d_q[2]);
                    8'b00001???: disp_d = d_q[2];
                    8'b000001??: inc_d  = d_q[1];
                    8'b0000001?: addr_d = 7'h00;
                    8'b00000001: begin
                        for (int i = 0; i < 32; i++) shadow_d[i] = SPACE;
                        addr_d = 7'h00;
                        inc_d  = 1'b1;
                    end
                    default: ;  // CGRAM address, function set and 0x00 change nothing
                endcase
            end
        end
    end

    // NOTE: the shadow is built from flops, not RAM, because clear rewrites all 32 entries in one edge;
    // that is also why it can carry a reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow_q[i] <= SPACE;
            addr_q     <= 7'h00;
            disp_q     <= 1'b0;
            inc_q      <= 1'b1;
            cmd_stb_q  <= 1'b0;
            data_stb_q <= 1'b0;
            rw_err_q   <= 1'b0;
            rd_char_q  <= 8'h00;
        end else begin
            shadow_q   <= shadow_d;
            addr_q     <= addr_d;
            disp_q     <= disp_d;
            inc_q      <= inc_d;
            cmd_stb_q  <= cmd_stb_d;
            data_stb_q <= data_stb_d;
            rw_err_q   <= rw_err_d;
            rd_char_q  <= shadow_q[rd_addr];  // read-before-write on a same-edge update
        end
    end

    assign rd_char   = rd_char_q;
    assign cur_addr  = addr_q;
    assign disp_on   = disp_q;
    assign entry_inc = inc_q;
    assign cmd_stb   = cmd_stb_q;
    assign data_stb  = data_stb_q;
    assign rw_err    = rw_err_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Self-checking bench for lcd_bus_decoder: directed steps followed by random strobes checked against
// a DDRAM-level reference model. Busy-mode steps are included when LCD_BUSY_EN is defined.
module tb_lcd_bus_decoder;

    localparam int BUSY_LONG  = 16;
    localparam int BUSY_SHORT = 2;
`ifdef LCD_BUSY_EN
    localparam bit BUSY_MODE = 1'b1;
    localparam int GAP       = BUSY_LONG + 2;
`else
    localparam bit BUSY_MODE = 1'b0;
    localparam int GAP       = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       LCD_E, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] cur_addr;
    logic       disp_on, entry_inc, cmd_stb, data_stb, rw_err, busy;
    logic [7:0] drop_cnt;

    lcd_bus_decoder #(.BUSY_LONG(BUSY_LONG), .BUSY_SHORT(BUSY_SHORT)) dut (
        .clk(clk), .rst(rst), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA),
        .rd_addr(rd_addr), .rd_char(rd_char), .cur_addr(cur_addr), .disp_on(disp_on),
        .entry_inc(entry_inc), .cmd_stb(cmd_stb), .data_stb(data_stb), .rw_err(rw_err),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the visible shadow, the DDRAM cursor and the mode bits.
    int unsigned m_shadow [32];
    int unsigned m_addr;
    bit          m_disp, m_inc;
    int unsigned m_drop;
    bit          exp_cmd, exp_data, exp_rwe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // DDRAM seen as one 80-position ring: line 1 = 0x00-0x27, line 2 = 0x40-0x67.
    function automatic int unsigned next_addr(input int unsigned a, input bit up);
        int unsigned lin;
        if (a <= 'h27)                   lin = a;
        else if (a >= 'h40 && a <= 'h67) lin = a - 'h40 + 40;
        else                             return (up ? a + 1 : a - 1) & 'h7F;
        lin = (lin + (up ? 1 : 79)) % 80;
        return (lin < 40) ? lin : lin - 40 + 'h40;
    endfunction

    task automatic model_apply(input bit rs, input bit rw, input int unsigned d);
        int msb;
        exp_cmd  = 1'b0;
        exp_data = 1'b0;
        exp_rwe  = 1'b0;
        if (rw) begin
            exp_rwe = 1'b1;
            return;
        end
        if (rs) begin
            if (m_addr < 16)                        m_shadow[m_addr] = d;
            else if (m_addr >= 'h40 && m_addr < 'h50) m_shadow[m_addr - 'h40 + 16] = d;
            m_addr   = next_addr(m_addr, m_inc);
            exp_data = 1'b1;
            return;
        end
        exp_cmd = 1'b1;
        msb = -1;
        for (int b = 0; b < 8; b++) if (((d >> b) & 1) != 0) msb = b;
        case (msb)
            7: m_addr = d & 'h7F;
            4: if (((d >> 3) & 1) == 0) m_addr = next_addr(m_addr, ((d >> 2) & 1) != 0);
            3: m_disp = ((d >> 2) & 1) != 0;
            2: m_inc  = ((d >> 1) & 1) != 0;
            1: m_addr = 0;
            0: begin
                for (int i = 0; i < 32; i++) m_shadow[i] = 'h20;
                m_addr = 0;
                m_inc  = 1'b1;
            end
            default: ;
        endcase
    endtask

    // One E pulse; ends at the falling clock edge just after the detecting edge.
    task automatic bus_strobe(input bit rs, input bit rw, input int unsigned d);
        @(negedge clk);
        LCD_E = 1'b1; LCD_RS = rs; LCD_RW = rw; LCD_DATA = 8'(d);
        @(negedge clk);
        LCD_E = 1'b0; LCD_RS = 1'($urandom); LCD_RW = 1'($urandom); LCD_DATA = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic do_strobe(input bit rs, input bit rw, input int unsigned d);
        model_apply(rs, rw, d);
        bus_strobe(rs, rw, d);
        check($sformatf("cmd_stb d=%02h", d), cmd_stb, exp_cmd);
        check($sformatf("data_stb d=%02h", d), data_stb, exp_data);
        check($sformatf("rw_err d=%02h", d), rw_err, exp_rwe);
        check($sformatf("cur_addr d=%02h", d), cur_addr, m_addr);
        check("disp_on", disp_on, m_disp);
        check("entry_inc", entry_inc, m_inc);
        check("busy_after", busy, BUSY_MODE && !rw);
        check("drop_cnt", drop_cnt, m_drop);
        @(negedge clk);
        check("pulses_low", {cmd_stb, data_stb, rw_err}, 3'b000);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic read_chk(input int idx);
        @(negedge clk);
        rd_addr = 5'(idx);
        @(negedge clk);
        check($sformatf("rd_char[%0d]", idx), rd_char, m_shadow[idx]);
    endtask

    task automatic sweep();
        for (int i = 0; i < 32; i++) read_chk(i);
    endtask

    initial begin
        int pulses;
        int unsigned r, d;
        bit rs, rw;

        for (int i = 0; i < 32; i++) m_shadow[i] = 'h20;
        m_addr = 0; m_disp = 1'b0; m_inc = 1'b1; m_drop = 0;

        // Reset with E held high: the first edge after reset must not see a strobe.
        rst = 1'b1; LCD_E = 1'b1; LCD_RS = 1'b1; LCD_RW = 1'b0; LCD_DATA = 8'h55; rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        check("rst rd_char", rd_char, 8'h00);
        check("rst strobes", {cmd_stb, data_stb, rw_err}, 3'b000);
        check("rst busy", busy, 1'b0);
        check("rst drop_cnt", drop_cnt, 8'h00);
        rst = 1'b0; LCD_E = 1'b0;
        @(negedge clk);
        check("no first strobe", data_stb, 1'b0);
        check("rst cur_addr", cur_addr, 7'h00);
        check("rst entry_inc", entry_inc, 1'b1);
        check("rst disp_on", disp_on, 1'b0);
        sweep();

        // Display on, two characters on line 1.
        do_strobe(0, 0, 'h0C);
        do_strobe(1, 0, 'h41);
        do_strobe(1, 0, 'h42);
        check("plan disp_on", disp_on, 1'b1);
        check("plan cur 02", cur_addr, 7'h02);
        read_chk(0); read_chk(1);
        check("plan rd0", m_shadow[0], 'h41);

        // Line 2.
        do_strobe(0, 0, 'hC0);
        do_strobe(1, 0, 'h31);
        do_strobe(1, 0, 'h32);
        check("plan cur 42", cur_addr, 7'h42);
        read_chk(16); read_chk(17);

        // Wraps and the hidden area.
        do_strobe(0, 0, 'hCF); do_strobe(1, 0, 'h5A);
        check("plan cur 50", cur_addr, 7'h50);
        do_strobe(1, 0, 'h7E);
        check("plan cur 51", cur_addr, 7'h51);
        do_strobe(0, 0, 'hA7); do_strobe(1, 0, 'h61);
        check("plan cur 40", cur_addr, 7'h40);
        do_strobe(0, 0, 'hE7); do_strobe(1, 0, 'h62);
        check("plan cur 00", cur_addr, 7'h00);
        do_strobe(0, 0, 'h04); do_strobe(1, 0, 'h63);
        check("plan cur 67", cur_addr, 7'h67);
        do_strobe(0, 0, 'h06);
        sweep();

        // Fill everything, then clear.
        do_strobe(0, 0, 'h80);
        for (int i = 0; i < 16; i++) do_strobe(1, 0, 'h41 + i);
        do_strobe(0, 0, 'hC0);
        for (int i = 0; i < 16; i++) do_strobe(1, 0, 'h61 + i);
        sweep();
        do_strobe(0, 0, 'h01);
        check("clear cur", cur_addr, 7'h00);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); rd_addr = 5'(i);
            @(negedge clk); check($sformatf("clear rd[%0d]", i), rd_char, 8'h20);
        end

        // Read strobe: only rw_err.
        do_strobe(0, 0, 'h85);
        do_strobe(1, 1, 'h33);
        check("rw cur kept", cur_addr, 7'h05);
        sweep();

`ifndef LCD_BUSY_EN
        // Back-to-back strobes every two cycles.
        do_strobe(0, 0, 'h80);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (data_stb === 1'b1) pulses++;
            if (c < 8) begin
                LCD_E = (c % 2 == 0);
                if (c % 2 == 0) begin
                    LCD_RS = 1'b1; LCD_RW = 1'b0; LCD_DATA = 8'('h71 + c / 2);
                    model_apply(1, 0, 'h71 + c / 2);
                end
            end
        end
        check("burst pulses", pulses, 4);
        check("burst cur", cur_addr, 7'h04);
        sweep();
`else
        // Busy: clear, a dropped data write, a read strobe while busy, then an accepted write.
        model_apply(0, 0, 'h01);
        bus_strobe(0, 0, 'h01);
        check("busy clr stb", cmd_stb, 1'b1);
        check("busy set", busy, 1'b1);
        @(negedge clk);
        bus_strobe(1, 0, 'h41);
        m_drop = 1;
        check("drop data_stb", data_stb, 1'b0);
        check("drop cnt", drop_cnt, 8'd1);
        bus_strobe(0, 1, 'h00);
        check("busy rw_err", rw_err, 1'b1);
        check("busy rw cnt", drop_cnt, 8'd1);
        repeat (8) @(negedge clk);
        check("busy last", busy, 1'b1);
        @(negedge clk);
        check("busy over", busy, 1'b0);
        @(negedge clk);
        model_apply(1, 0, 'h41);
        bus_strobe(1, 0, 'h41);
        check("late data_stb", data_stb, 1'b1);
        check("late cur", cur_addr, 7'h01);
        repeat (GAP) @(negedge clk);
        read_chk(0);
        check("late rd0", m_shadow[0], 'h41);
`endif

        // Random strobes against the model.
        for (int n = 0; n < 240; n++) begin
            r = $urandom_range(0, 99);
            rs = 1'b0; rw = 1'b0;
            if (r < 40)      begin rs = 1'b1; d = $urandom_range('h20, 'h7E); end
            else if (r < 55) d = 'h80 | (($urandom_range(0, 3) != 0) ?
                                 ($urandom_range(0, 1) != 0 ? $urandom_range(0, 'h27)
                                                            : $urandom_range('h40, 'h67))
                                 : $urandom_range(0, 'h7F));
            else if (r < 62) d = 'h10 | $urandom_range(0, 15);
            else if (r < 68) d = 'h08 | $urandom_range(0, 7);
            else if (r < 76) d = 'h04 | $urandom_range(0, 3);
            else if (r < 80) d = 'h02 | $urandom_range(0, 1);
            else if (r < 82) d = 'h01;
            else if (r < 88) begin rw = 1'b1; rs = 1'($urandom); d = $urandom_range(0, 255); end
            else             d = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range('h20, 'h7F);
            do_strobe(rs, rw, d);
            if (n % 60 == 59) sweep();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
